// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into press / long-hold events and serialises
// them onto a single valid/ready event port with round-robin fairness.
module button_event_arbiter #(
  parameter int unsigned N_BTN       = 4,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [N_BTN-1:0]                      btn_level,
  input  logic                                  evt_ready,
  output logic                                  evt_valid,
  output logic [((N_BTN > 1) ? $clog2(N_BTN) : 1)-1:0] evt_btn,
  output logic                                  evt_hold,
  output logic                                  overrun
);

  localparam int unsigned BW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t             state_q, state_d;
  logic [N_BTN-1:0]   prev_level;
  logic [N_BTN-1:0]   press_pend, hold_pend;
  logic [N_BTN-1:0]   press_set, hold_set;
  logic [N_BTN-1:0]   clr_press, clr_hold;
  logic [CNT_W-1:0]   hold_cnt [N_BTN];
  logic [BW-1:0]      rr_ptr, rr_d;
  logic [BW-1:0]      grant_idx;
  logic               found;
  logic               evt_valid_d, evt_hold_d;
  logic [BW-1:0]      evt_btn_d;

  function automatic logic [BW-1:0] add_mod(input logic [BW-1:0] a, input int unsigned b);
    logic [BW:0] s;
    s = {1'b0, a} + (BW+1)'(b);
    if (s >= (BW+1)'(N_BTN)) s = s - (BW+1)'(N_BTN);
    return s[BW-1:0];
  endfunction

  // Event sources: rising edges and the single terminal-count cycle of each counter
  always_comb begin
    press_set = btn_level & ~prev_level;
    hold_set  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      hold_set[i] = btn_level[i] && (hold_cnt[i] == CNT_W'(HOLD_CYCLES - 1));
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_cnt
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hold_cnt[g] <= '0;
      end else if (!btn_level[g]) begin
        hold_cnt[g] <= '0;
      end else if (hold_cnt[g] < CNT_W'(HOLD_CYCLES)) begin
        hold_cnt[g] <= hold_cnt[g] + CNT_W'(1);
      end
    end
  end

  // Round-robin scan starting at rr_ptr; first button with any pending event wins
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_BTN; k++) begin
      if (!found && (press_pend[add_mod(rr_ptr, k)] || hold_pend[add_mod(rr_ptr, k)])) begin
        found     = 1'b1;
        grant_idx = add_mod(rr_ptr, k);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      evt_valid <= 1'b0;
      evt_btn   <= '0;
      evt_hold  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr    <= rr_d;
      evt_valid <= evt_valid_d;
      evt_btn   <= evt_btn_d;
      evt_hold  <= evt_hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_ptr;
    evt_valid_d = evt_valid;
    evt_btn_d   = evt_btn;
    evt_hold_d  = evt_hold;
    clr_press   = '0;
    clr_hold    = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = PRESENT;
          evt_valid_d = 1'b1;
          evt_btn_d   = grant_idx;
          evt_hold_d  = ~press_pend[grant_idx];
          rr_d        = add_mod(grant_idx, 1);
          if (press_pend[grant_idx]) clr_press[grant_idx] = 1'b1;
          else                       clr_hold[grant_idx]  = 1'b1;
        end
      end
      PRESENT: begin
        if (evt_ready) begin
          state_d     = IDLE;
          evt_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new set beats a same-cycle clear; a set onto a still-pending bit is a lost event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_level <= '0;
      press_pend <= '0;
      hold_pend  <= '0;
      overrun    <= 1'b0;
    end else begin
      prev_level <= btn_level;
      press_pend <= press_set | (press_pend & ~clr_press);
      hold_pend  <= hold_set | (hold_pend & ~clr_hold);
      if (|(press_set & press_pend & ~clr_press) || |(hold_set & hold_pend & ~clr_hold))
        overrun <= 1'b1;
    end
  end

endmodule
